// File: rtl/slow_mem_responder.sv
// slow_mem_responder: line-granular memory model with a fixed response latency.
// A held read/write request is accepted in IDLE, counted down in WAIT and
// completed with a one-cycle mem_ready pulse in RESP. Protocol violations
// (read+write together, request dropped mid-wait) raise a one-cycle err pulse.
module slow_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [27:0]           mem_addr,
  input  logic [127:0]          mem_wdata,
  output logic [127:0]          mem_rdata,
  output logic                  mem_ready,
  input  logic                  init_wen,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [127:0]          init_data,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    op_wr, op_wr_nxt;
  logic [DEPTH_LOG2-1:0]   addr_lat, addr_lat_nxt;
  logic [127:0]            wdata_lat, wdata_lat_nxt;
  logic                    err_nxt;
  logic                    req;
  logic                    load_rdata;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    unused_addr_hi;

  logic [127:0] mem [2**DEPTH_LOG2];

  assign req            = mem_read | mem_write;
  // Upper line-address bits alias away; only the low DEPTH_LOG2 bits index the array.
  assign unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_wr_nxt     = op_wr;
    addr_lat_nxt  = addr_lat;
    wdata_lat_nxt = wdata_lat;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          op_wr_nxt     = mem_write;          // write wins when both are high
          addr_lat_nxt  = mem_addr[DEPTH_LOG2-1:0];
          wdata_lat_nxt = mem_wdata;
          cnt_nxt       = 4'(LATENCY - 1);
          err_nxt       = mem_read & mem_write;
          state_nxt     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // Initiator gave up: abandon silently apart from the err pulse.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= (state_nxt == RESP);
      err       <= err_nxt;
    end
  end

  // Request latches; plain data, no reset needed.
  always_ff @(posedge clk) begin
    op_wr     <= op_wr_nxt;
    addr_lat  <= addr_lat_nxt;
    wdata_lat <= wdata_lat_nxt;
  end

  // With LATENCY=1 the read goes straight from IDLE to RESP, before the address latch is loaded.
  assign rd_idx     = (state == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : addr_lat;
  assign load_rdata = (state_nxt == RESP) && !op_wr_nxt;

  // Read data register: loaded on entry to RESP for reads, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 128'h0;
    end else if (load_rdata) begin
      mem_rdata <= mem[rd_idx];
    end
  end

  // Line array: preload port first so a same-line RESP write on the same edge overrides it.
  always_ff @(posedge clk) begin
    if (init_wen) mem[init_addr] <= init_data;
    if (!rst && state == RESP && op_wr) mem[addr_lat] <= wdata_lat;
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder: one default-latency instance and one LATENCY=1 instance.
module tb_slow_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, err;
  logic         init_wen;
  logic [5:0]   init_addr;
  logic [127:0] init_data;

  logic         rd1, wr1, ready1, err1, iwen1;
  logic [27:0]  addr1;
  logic [127:0] wdata1, rdata1, idata1;
  logic [5:0]   iaddr1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  slow_mem_responder u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .init_wen(init_wen), .init_addr(init_addr),
    .init_data(init_data), .err(err)
  );

  slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(6)) u_fast (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .mem_ready(ready1), .init_wen(iwen1), .init_addr(iaddr1),
    .init_data(idata1), .err(err1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [127:0] d);
    init_wen = 1'b1; init_addr = a; init_data = d;
    tick();
    init_wen = 1'b0;
  endtask

  // Hold a request until mem_ready (bounded); a2 replaces the address after the first cycle.
  // Returns in the mem_ready cycle with the request dropped.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [27:0] a, input logic [27:0] a2,
                     input logic [127:0] d, input int exp_lat, input int exp_err);
    int n = 0;
    int e = 0;
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    do begin
      tick();
      n++;
      mem_addr  = a2;
      mem_wdata = ~d;
      if (err) e++;
    end while (!mem_ready && n < 20);
    mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
    chk({tag, "_err"}, 128'(e), 128'(exp_err));
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    init_wen = 0; init_addr = '0; init_data = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0; iwen1 = 0; iaddr1 = '0; idata1 = '0;
    tick(); tick();
    chk("rst_ready", 128'(mem_ready), 128'(0));
    chk("rst_err",   128'(err),       128'(0));
    chk("rst_rdata", mem_rdata,       128'h0);

    // Preload during reset: the array port ignores rst.
    preload(6'd3, PAT_A5);
    preload(6'd9, 128'h0);
    iwen1 = 1'b1; iaddr1 = 6'd2; idata1 = 128'h55;
    tick();
    iwen1 = 1'b0;
    rst = 1'b0;
    tick();

    // Basic read of preloaded line, 4-cycle latency, one-cycle pulse.
    txn("rd3", 1, 0, 28'h3, 28'h3, '0, 4, 0);
    chk("rd3_data", mem_rdata, PAT_A5);
    tick();
    chk("rd3_pulse", 128'(mem_ready), 128'(0));

    // Write then aliased read; rdata unchanged by the write.
    txn("wr5", 0, 1, 28'h5, 28'h5, 128'h1234, 4, 0);
    chk("wr5_rdata_hold", mem_rdata, PAT_A5);
    tick();
    txn("rd45", 1, 0, 28'h45, 28'h45, '0, 4, 0);
    chk("rd45_data", mem_rdata, 128'h1234);
    tick();

    // Read and write together: write wins, err pulses once.
    txn("rw7", 1, 1, 28'h7, 28'h7, 128'hFF, 4, 1);
    tick();
    txn("rd7", 1, 0, 28'h7, 28'h7, '0, 4, 0);
    chk("rd7_data", mem_rdata, 128'hFF);
    tick();

    // Address changes during WAIT are ignored.
    txn("rd3b", 1, 0, 28'h3, 28'h5, '0, 4, 0);
    chk("rd3b_data", mem_rdata, PAT_A5);
    tick();

    // Request dropped after two cycles: abort, err pulse, no ready.
    mem_read = 1'b1; mem_addr = 28'h5;
    tick(); tick();
    mem_read = 1'b0;
    tick();
    chk("abort_err",   128'(err),       128'(1));
    chk("abort_ready", 128'(mem_ready), 128'(0));
    begin
      int rdy = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (mem_ready) rdy++; end
      chk("abort_no_ready", 128'(rdy), 128'(0));
    end
    txn("rd_after_abort", 1, 0, 28'h5, 28'h5, '0, 4, 0);
    chk("rd_after_abort_data", mem_rdata, 128'h1234);
    tick();

    // Reset during WAIT of a write to line 9; read requested in the first cycle after reset.
    mem_write = 1'b1; mem_addr = 28'h9; mem_wdata = 128'hDEAD;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", 128'(mem_ready), 128'(0));
    rst = 1'b0; mem_write = 1'b0;
    txn("rd9", 1, 0, 28'h9, 28'h9, '0, 4, 0);
    chk("rd9_data", mem_rdata, 128'h0);
    tick();

    // RESP write beats a coinciding preload of the same line.
    txn("wr11", 0, 1, 28'hB, 28'hB, 128'h77, 4, 0);
    init_wen = 1'b1; init_addr = 6'd11; init_data = 128'h88;
    tick();
    init_wen = 1'b0;
    txn("rd11", 1, 0, 28'hB, 28'hB, '0, 4, 0);
    chk("rd11_data", mem_rdata, 128'h77);
    tick();

    // LATENCY=1: continuously held read pulses ready every other cycle.
    rd1 = 1'b1; addr1 = 28'h2;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("fast_ready_%0d", i), 128'(ready1), 128'(i % 2));
      if (i == 1) chk("fast_data", rdata1, 128'h55);
      chk($sformatf("fast_err_%0d", i), 128'(err1), 128'(0));
    end
    rd1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slow_mem_responder.md
SLOW_MEM_RESPONDER -- requirements
Module: slow_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from first request cycle to mem_ready cycle; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6: number of 128-bit lines is 2**DEPTH_LOG2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port mem_read, input, 1: line read request, held high by initiator until mem_ready seen.
REQ-006 SHALL have port mem_write, input, 1: line write request, same holding rule.
REQ-007 SHALL have port mem_addr, input, 28: line address (byte address bits 31:4).
REQ-008 SHALL have port mem_wdata, input, 128: write line data.
REQ-009 SHALL have port mem_rdata, output, 128: read line data, registered.
REQ-010 SHALL have port mem_ready, output, 1: one-cycle completion pulse, registered.
REQ-011 SHALL have port init_wen, input, 1: preload write strobe from bench/boot logic.
REQ-012 SHALL have port init_addr, input, DEPTH_LOG2: preload line index.
REQ-013 SHALL have port init_data, input, 128: preload line data.
REQ-014 SHALL have port err, output, 1: one-cycle pulse on protocol violation.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, when mem_read or mem_write is high at a clock edge, SHALL latch op, mem_addr[DEPTH_LOG2-1:0] and mem_wdata, load counter with LATENCY-1, and go to RESP if LATENCY=1, else WAIT.
REQ-017 In WAIT, SHALL decrement counter each cycle; on the edge where counter is 1 SHALL go to RESP.
REQ-018 mem_ready SHALL be high exactly in RESP state: request first high in cycle T gives mem_ready high in cycle T+LATENCY for one cycle.
REQ-019 On a read, mem_rdata SHALL present array[latched addr] in the mem_ready cycle and hold it until the next read completes.
REQ-020 On a write, the array line SHALL be updated with latched wdata on the edge ending the RESP cycle; mem_rdata unchanged.
REQ-021 RESP SHALL always return to IDLE; a request seen high in the RESP cycle SHALL NOT start a new transaction; a request still high in the following IDLE cycle SHALL start a new one.
REQ-022 mem_addr bits above DEPTH_LOG2-1 SHALL be ignored (addresses alias modulo depth).
REQ-023 mem_read and mem_write both high in IDLE: write SHALL take priority and err SHALL pulse in the following cycle.
REQ-024 Request dropped (both low) while in WAIT: SHALL abort to IDLE, no array write, no mem_ready, err pulses next cycle.
REQ-025 mem_addr, mem_wdata and op changes during WAIT SHALL be ignored (latched values used).
REQ-026 init_wen SHALL write init_data to array[init_addr] on that edge in any state; if it coincides with a RESP write to the same line, the RESP write SHALL win.
REQ-027 The array SHALL be plain storage without reset; a read of a never-written line returns undefined data.

Reset
REQ-028 While rst is high at an edge: state IDLE, counter 0, mem_ready 0, err 0, mem_rdata 128'h0.
REQ-029 Reset mid-transaction SHALL abandon it: no mem_ready, no array write; array contents preserved.
REQ-030 A request high in the first cycle after rst falls SHALL be accepted normally per REQ-016.

Verification
REQ-031 Preload line 3 = 128'hA5A5...A5; read addr 28'h3 held from cycle T (LATENCY=4) -> mem_ready high only in T+4, mem_rdata = A5 pattern, err 0.
REQ-032 Write addr 28'h5 data 128'h1234 then read 28'h45 (aliases to 5 with DEPTH_LOG2=6) -> read returns 128'h1234.
REQ-033 Read and write both high on addr 7 with data 128'hFF -> err pulse, line 7 = 128'hFF, mem_ready after 4 cycles.
REQ-034 Read issued then dropped after 2 cycles -> no mem_ready, err pulse, next read starts a fresh 4-cycle count.
REQ-035 rst asserted in WAIT of a write to line 9 (preloaded 0) -> mem_ready stays 0, subsequent read of line 9 returns 0.
REQ-036 LATENCY=1 back-to-back reads held continuously -> mem_ready pulses every 2 cycles, never two consecutive cycles.
